// File: rtl/sha256_pad_sched.sv
// SHA-256 single-block padder and message-schedule streamer.
// Emits W0..W63 over a valid/ready handshake from a 16-word sliding window.
module sha256_pad_sched #(
    parameter int MSG_WIDTH = 24
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic [MSG_WIDTH-1:0] msg_i,
    output logic [31:0]          w_o,
    output logic [5:0]           w_idx_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int SH = 504 - MSG_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]          r_win [16];
    logic [5:0]           r_t;
    logic [MSG_WIDTH+7:0] w_head;
    logic [511:0]         w_blk;
    logic [31:0]          w_nw;
    logic                 w_load;
    logic                 w_fire;

    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Message and 0x80 marker left-justified; bit length in the low 64 bits.
    assign w_head = {msg_i, 8'h80};
    assign w_blk  = (512'(w_head) << SH) | 512'(MSG_WIDTH);

    assign w_nw = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

    assign w_load = (r_state == S_IDLE) && start_i && !clear_i;
    assign w_fire = (r_state == S_RUN) && w_ready_i && !clear_i;

    assign w_o     = r_win[0];
    assign w_idx_o = r_t;

    always_comb begin
        w_next    = r_state;
        w_valid_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_RUN;
            end
            S_RUN: begin
                w_valid_o = 1'b1;
                busy_o    = 1'b1;
                if (w_ready_i && r_t == 6'd63) w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (clear_i) w_next = S_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else begin
            r_state <= w_next;
            if (clear_i) begin
                r_t <= '0;
                for (int i = 0; i < 16; i++) r_win[i] <= '0;
            end else if (w_load) begin
                r_t <= '0;
                for (int i = 0; i < 16; i++) r_win[i] <= w_blk[511-32*i -: 32];
            end else if (w_fire) begin
                // Counter parks at 0 after W63 instead of wrapping through it.
                r_t <= (r_t == 6'd63) ? 6'd0 : r_t + 6'd1;
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                r_win[15] <= w_nw;
            end
        end
    end

endmodule
